imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Write-side companion of instruction_memory: fills the instruction store before the core runs.
//  Takes a byte stream over a valid/ready handshake and packs each 4 bytes into a little-endian 32-bit word.
//  Writes the words to consecutive word-aligned addresses starting at 0x0.
//  Holds the core in reset via cpu_hold while a load is in progress.
// PARAMETERS
//  DATA_WIDTH     32   instruction word width; fixed at 32 (4 bytes per word)
//  ADDRESS_WIDTH  32   byte-address width of the write port
//  MEM_SIZE       256  capacity in words; legal word indices 0..MEM_SIZE-1
// PORTS
//  clk         in   1                        single clock, rising edge
//  rst_n       in   1                        asynchronous reset, active-low
//  start       in   1                        pulse: begin a load; sampled in IDLE only
//  num_words   in   $clog2(MEM_SIZE+1)       words to load; latched when start is accepted
//  byte_valid  in   1                        byte_data is valid
//  byte_data   in   8                        stream byte
//  byte_ready  out  1                        loader accepts a byte this cycle
//  we          out  1                        one-cycle write strobe to the memory
//  waddr       out  ADDRESS_WIDTH            byte address of the write; bits[1:0] always 0
//  wdata       out  DATA_WIDTH               assembled instruction word
//  busy        out  1                        load in progress (RECV or WRITE)
//  cpu_hold    out  1                        equals busy; holds the core in reset
//  done        out  1                        one-cycle pulse when the load completes
//  err         out  1                        sticky: num_words > MEM_SIZE; cleared by the next accepted start
// BEHAVIOUR
//  States: IDLE -> RECV -> WRITE -> (RECV | DONE) -> IDLE.
//  Reset (rst_n=0, asynchronous)
//   - All outputs 0; state IDLE; word_idx=0; byte_idx=0.
//   - Mid-load reset discards any partial word; words already written stay in memory.
//  All outputs are registered.
//  IDLE
//   - byte_ready=0.
//   - On start: latch n = min(num_words, MEM_SIZE); err <= (num_words > MEM_SIZE).
//   - n==0: go to DONE, no writes. Otherwise go to RECV with word_idx=0, byte_idx=0.
//  RECV
//   - byte_ready=1; a byte transfers when byte_valid & byte_ready.
//   - Byte k of a word (k=0..3) lands in wdata[8k+7:8k]; the first byte is the LSB.
//   - byte_idx wraps 3->0. The 4th accepted byte moves the FSM to WRITE.
//   - Cycles with byte_valid=0 are stalls; nothing changes.
//  WRITE
//   - Lasts 1 cycle; byte_ready=0.
//   - we=1, waddr=word_idx<<2, wdata stays stable.
//   - Latency: 4th byte accepted at edge N -> we high during cycle N+1.
//   - If word_idx==n-1: go to DONE. Else word_idx++ and go to RECV.
//   - Peak throughput: 1 word per 5 cycles.
//  DONE
//   - done=1 for exactly 1 cycle, then IDLE.
//   - busy/cpu_hold fall in the same cycle done rises.
//  Other rules
//   - start while busy: ignored.
//   - byte_valid in IDLE, WRITE or DONE: ignored; byte_ready is 0 there, so no byte is lost.
//   - word_idx never exceeds MEM_SIZE-1, so waddr never exceeds (MEM_SIZE-1)*4 = 0x3FC.
// TESTING
//  T1  reset; start, num_words=1; bytes 13,00,00,00 back-to-back
//      -> one we: waddr=0x0, wdata=0x00000013; done pulse; busy=0 after.
//  T2  num_words=3; 12 bytes 00..0B with random valid gaps
//      -> writes 0x0:0x03020100, 0x4:0x07060504, 0x8:0x0B0A0908; exactly 3 we pulses.
//  T3  num_words=300
//      -> err=1; 256 writes, last at waddr=0x3FC; next start with num_words=1 clears err.
//  T4  num_words=0 -> done one cycle after start; no we; busy stays 0.
//  T5  rst_n low after 2 bytes of word 1, while busy
//      -> all outputs 0 immediately; new load restarts at waddr=0x0.
//  T6  start pulsed during RECV -> ignored; byte_valid during WRITE -> byte_ready=0, byte held for next RECV.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: fills the instruction memory from a byte stream before the core runs.
// Four accepted bytes are packed little-endian into one 32-bit word. Words go to
// consecutive word-aligned addresses starting at 0x0. cpu_hold keeps the core in
// reset while a load is in progress. Every output comes straight from a flop.
module imem_loader #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int MEM_SIZE      = 256,
    localparam int CNT_W        = $clog2(MEM_SIZE + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [CNT_W-1:0]         num_words,
    input  logic                     byte_valid,
    input  logic [7:0]               byte_data,
    output logic                     byte_ready,
    output logic                     we,
    output logic [ADDRESS_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0]    wdata,
    output logic                     busy,
    output logic                     cpu_hold,
    output logic                     done,
    output logic                     err
);

    localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam logic [CNT_W-1:0] MEM_SIZE_C = CNT_W'(MEM_SIZE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         n_q, n_d;
    logic [IDX_W-1:0]         word_idx_q, word_idx_d;
    logic [1:0]               byte_idx_q, byte_idx_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [ADDRESS_WIDTH-1:0] waddr_q, waddr_d;
    logic                     we_q, we_d;
    logic                     byte_ready_q, byte_ready_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;
    logic                     byte_accept;
    logic                     last_word;

    // Next-state logic; registered outputs are derived from the next state so they track the state register.
    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        word_idx_d   = word_idx_q;
        byte_idx_d   = byte_idx_q;
        wdata_d      = wdata_q;
        waddr_d      = waddr_q;
        err_d        = err_q;
        byte_accept  = (state_q == S_RECV) && byte_valid && byte_ready_q;
        last_word    = (CNT_W'(word_idx_q) == (n_q - 1'b1));

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d      = (num_words > MEM_SIZE_C);
                    n_d        = (num_words > MEM_SIZE_C) ? MEM_SIZE_C : num_words;
                    word_idx_d = '0;
                    byte_idx_d = '0;
                    state_d    = (num_words == '0) ? S_DONE : S_RECV;
                end
            end
            S_RECV: begin
                if (byte_accept) begin
                    wdata_d[{byte_idx_q, 3'b000} +: 8] = byte_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        waddr_d = ADDRESS_WIDTH'({word_idx_q, 2'b00});
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (last_word) begin
                    state_d = S_DONE;
                end else begin
                    word_idx_d = word_idx_q + 1'b1;
                    state_d    = S_RECV;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        byte_ready_d = (state_d == S_RECV);
        we_d         = (state_d == S_WRITE);
        busy_d       = (state_d == S_RECV) || (state_d == S_WRITE);
        done_d       = (state_d == S_DONE);
    end

    // State and output registers; reset drops every output to 0 at once and discards a partial word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            n_q          <= '0;
            word_idx_q   <= '0;
            byte_idx_q   <= '0;
            wdata_q      <= '0;
            waddr_q      <= '0;
            we_q         <= 1'b0;
            byte_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            word_idx_q   <= word_idx_d;
            byte_idx_q   <= byte_idx_d;
            wdata_q      <= wdata_d;
            waddr_q      <= waddr_d;
            we_q         <= we_d;
            byte_ready_q <= byte_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign byte_ready = byte_ready_q;
    assign we         = we_q;
    assign waddr      = waddr_q;
    assign wdata      = wdata_q;
    assign busy       = busy_q;
    assign cpu_hold   = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized scenarios for imem_loader checked against a queue model
// that derives the expected memory writes directly from the byte stream.
module tb_imem_loader;

    localparam int MEM_SIZE = 256;
    localparam int CNT_W    = $clog2(MEM_SIZE + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] num_words = '0;
    logic             byte_valid = 1'b0;
    logic [7:0]       byte_data = '0;
    logic             byte_ready;
    logic             we;
    logic [31:0]      waddr;
    logic [31:0]      wdata;
    logic             busy;
    logic             cpu_hold;
    logic             done;
    logic             err;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int done_cnt = 0;
    logic [31:0] act_addr[$];
    logic [31:0] act_data[$];
    logic [7:0]  stim[$];

    imem_loader #(
        .DATA_WIDTH(32),
        .ADDRESS_WIDTH(32),
        .MEM_SIZE(MEM_SIZE)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .num_words(num_words),
        .byte_valid(byte_valid),
        .byte_data(byte_data),
        .byte_ready(byte_ready),
        .we(we),
        .waddr(waddr),
        .wdata(wdata),
        .busy(busy),
        .cpu_hold(cpu_hold),
        .done(done),
        .err(err)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Edge counter used for latency checks.
    always @(posedge clk) cyc++;

    // Record every memory write and done pulse seen mid-cycle.
    always @(negedge clk) begin
        if (we) begin
            act_addr.push_back(waddr);
            act_data.push_back(wdata);
        end
        if (done) done_cnt++;
    end

    // Expected word w: four consecutive stream bytes, first byte in the LSB.
    function automatic logic [31:0] exp_word(input int w);
        return {stim[4*w+3], stim[4*w+2], stim[4*w+1], stim[4*w]};
    endfunction

    task automatic clear_mon();
        act_addr.delete();
        act_data.delete();
        done_cnt = 0;
    endtask

    task automatic random_stim(input int nbytes);
        stim.delete();
        for (int i = 0; i < nbytes; i++) stim.push_back(8'($urandom));
    endtask

    task automatic pulse_start(input int nw);
        start = 1'b1;
        num_words = CNT_W'(nw);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_max, output bit ok);
        bit acc;
        ok = 1'b0;
        acc = 1'b0;
        repeat ($urandom_range(gap_max, 0)) begin
            @(posedge clk); #1;
        end
        byte_valid = 1'b1;
        byte_data = b;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            acc = byte_ready;
            @(posedge clk); #1;
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        byte_valid = 1'b0;
        byte_data = 8'($urandom);
    endtask

    task automatic send_range(input int first, input int last, input int gap_max, output bit ok);
        bit one;
        ok = 1'b1;
        for (int i = first; i <= last; i++) begin
            send_byte(stim[i], gap_max, one);
            if (!one) ok = 1'b0;
        end
    endtask

    task automatic wait_done(input int limit, output int at_cyc);
        bit seen;
        int c;
        at_cyc = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            seen = done;
            c = cyc;
            @(posedge clk); #1;
            if (seen) begin
                at_cyc = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({byte_ready, we, busy, cpu_hold, done, err} !== 6'b0)
            $display("[TB] FAIL reset_flags: got %b expected 000000", {byte_ready, we, busy, cpu_hold, done, err});
        else passes++;
        checks++;
        if (waddr !== 32'h0) $display("[TB] FAIL reset_waddr: got %h expected 0", waddr); else passes++;
        checks++;
        if (wdata !== 32'h0) $display("[TB] FAIL reset_wdata: got %h expected 0", wdata); else passes++;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_word();
        bit ok;
        stim.delete();
        stim.push_back(8'h13); stim.push_back(8'h00); stim.push_back(8'h00); stim.push_back(8'h00);
        clear_mon();
        pulse_start(1);
        checks++;
        if ({busy, cpu_hold, byte_ready} !== 3'b111)
            $display("[TB] FAIL t1_recv_flags: got %b expected 111", {busy, cpu_hold, byte_ready});
        else passes++;
        send_range(0, 3, 0, ok);
        checks++;
        if (!ok) $display("[TB] FAIL t1_bytes: got timeout expected all accepted"); else passes++;
        checks++;
        if ({we, byte_ready} !== 2'b10) $display("[TB] FAIL t1_we_latency: got %b expected 10", {we, byte_ready}); else passes++;
        checks++;
        if (waddr !== 32'h0 || wdata !== 32'h00000013)
            $display("[TB] FAIL t1_write: got %h:%h expected 00000000:00000013", waddr, wdata);
        else passes++;
        @(posedge clk); #1;
        checks++;
        if ({done, busy, cpu_hold, we} !== 4'b1000)
            $display("[TB] FAIL t1_done: got %b expected 1000", {done, busy, cpu_hold, we});
        else passes++;
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) $display("[TB] FAIL t1_done_width: got %b expected 0", done); else passes++;
        checks++;
        if (act_addr.size() != 1 || done_cnt != 1)
            $display("[TB] FAIL t1_counts: got %0d writes %0d dones expected 1 1", act_addr.size(), done_cnt);
        else passes++;
    endtask

    task automatic test_gaps();
        bit ok;
        int c;
        stim.delete();
        for (int i = 0; i < 12; i++) stim.push_back(8'(i));
        clear_mon();
        pulse_start(3);
        send_range(0, 11, 3, ok);
        wait_done(20, c);
        checks++;
        if (!ok || c < 0) $display("[TB] FAIL t2_complete: got ok=%0d done_at=%0d expected 1 and >=0", ok, c); else passes++;
        checks++;
        if (act_addr.size() != 3) $display("[TB] FAIL t2_we_count: got %0d expected 3", act_addr.size()); else passes++;
        for (int w = 0; w < 3; w++) begin
            checks++;
            if (act_addr[w] !== 32'(w * 4) || act_data[w] !== exp_word(w))
                $display("[TB] FAIL t2_word%0d: got %h:%h expected %h:%h", w, act_addr[w], act_data[w], 32'(w * 4), exp_word(w));
            else passes++;
        end
        checks++;
        if (done_cnt != 1 || busy !== 1'b0) $display("[TB] FAIL t2_end: got dones=%0d busy=%b expected 1 0", done_cnt, busy); else passes++;
    endtask

    task automatic test_overflow();
        bit ok;
        int c;
        int s;
        random_stim(4 * MEM_SIZE);
        clear_mon();
        pulse_start(300);
        s = cyc;
        checks++;
        if ({err, busy} !== 2'b11) $display("[TB] FAIL t3_err_set: got %b expected 11", {err, busy}); else passes++;
        send_range(0, 4 * MEM_SIZE - 1, 0, ok);
        wait_done(20, c);
        checks++;
        if (!ok || c != s + 5 * MEM_SIZE)
            $display("[TB] FAIL t3_throughput: got ok=%0d done_at=%0d expected 1 %0d", ok, c, s + 5 * MEM_SIZE);
        else passes++;
        checks++;
        if (act_addr.size() != MEM_SIZE) $display("[TB] FAIL t3_we_count: got %0d expected %0d", act_addr.size(), MEM_SIZE); else passes++;
        for (int w = 0; w < MEM_SIZE; w++) begin
            checks++;
            if (act_addr[w] !== 32'(w * 4) || act_data[w] !== exp_word(w))
                $display("[TB] FAIL t3_word%0d: got %h:%h expected %h:%h", w, act_addr[w], act_data[w], 32'(w * 4), exp_word(w));
            else passes++;
        end
        checks++;
        if (act_addr[act_addr.size() - 1] !== 32'h3FC)
            $display("[TB] FAIL t3_last_addr: got %h expected 000003fc", act_addr[act_addr.size() - 1]);
        else passes++;
        checks++;
        if (err !== 1'b1) $display("[TB] FAIL t3_err_sticky: got %b expected 1", err); else passes++;
        random_stim(4);
        clear_mon();
        pulse_start(1);
        checks++;
        if (err !== 1'b0) $display("[TB] FAIL t3_err_clear: got %b expected 0", err); else passes++;
        send_range(0, 3, 2, ok);
        wait_done(20, c);
        checks++;
        if (act_addr.size() != 1 || act_addr[0] !== 32'h0 || act_data[0] !== exp_word(0))
            $display("[TB] FAIL t3_reload: got %0d writes first %h:%h expected 1 00000000:%h", act_addr.size(), act_addr[0], act_data[0], exp_word(0));
        else passes++;
    endtask

    task automatic test_zero();
        clear_mon();
        pulse_start(0);
        checks++;
        if ({done, busy, cpu_hold, we, byte_ready} !== 5'b10000)
            $display("[TB] FAIL t4_done_now: got %b expected 10000", {done, busy, cpu_hold, we, byte_ready});
        else passes++;
        @(posedge clk); #1;
        checks++;
        if ({done, busy} !== 2'b00) $display("[TB] FAIL t4_idle: got %b expected 00", {done, busy}); else passes++;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (act_addr.size() != 0 || done_cnt != 1)
            $display("[TB] FAIL t4_counts: got %0d writes %0d dones expected 0 1", act_addr.size(), done_cnt);
        else passes++;
    endtask

    task automatic test_reset_midload();
        bit ok;
        int c;
        random_stim(8);
        clear_mon();
        pulse_start(3);
        send_range(0, 5, 0, ok);
        checks++;
        if (!ok || busy !== 1'b1) $display("[TB] FAIL t5_midload: got ok=%0d busy=%b expected 1 1", ok, busy); else passes++;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({byte_ready, we, busy, cpu_hold, done, err} !== 6'b0 || waddr !== 32'h0 || wdata !== 32'h0)
            $display("[TB] FAIL t5_async_reset: got %b %h %h expected 000000 0 0", {byte_ready, we, busy, cpu_hold, done, err}, waddr, wdata);
        else passes++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        random_stim(8);
        clear_mon();
        pulse_start(2);
        send_range(0, 7, 1, ok);
        wait_done(20, c);
        checks++;
        if (act_addr.size() != 2) $display("[TB] FAIL t5_we_count: got %0d expected 2", act_addr.size()); else passes++;
        for (int w = 0; w < 2; w++) begin
            checks++;
            if (act_addr[w] !== 32'(w * 4) || act_data[w] !== exp_word(w))
                $display("[TB] FAIL t5_word%0d: got %h:%h expected %h:%h", w, act_addr[w], act_data[w], 32'(w * 4), exp_word(w));
            else passes++;
        end
    endtask

    task automatic test_ignore();
        bit ok;
        bit ok2;
        int c;
        random_stim(8);
        clear_mon();
        pulse_start(2);
        send_range(0, 1, 0, ok);
        pulse_start(1);
        checks++;
        if (busy !== 1'b1) $display("[TB] FAIL t6_start_ignored: got busy=%b expected 1", busy); else passes++;
        send_range(2, 3, 0, ok2);
        byte_valid = 1'b1;
        byte_data = stim[4];
        @(negedge clk);
        checks++;
        if ({we, byte_ready} !== 2'b10) $display("[TB] FAIL t6_write_not_ready: got %b expected 10", {we, byte_ready}); else passes++;
        @(posedge clk); #1;
        send_range(4, 7, 0, ok);
        wait_done(20, c);
        checks++;
        if (!ok || !ok2 || c < 0 || act_addr.size() != 2 || done_cnt != 1)
            $display("[TB] FAIL t6_counts: got %0d writes %0d dones done_at=%0d expected 2 1", act_addr.size(), done_cnt, c);
        else passes++;
        for (int w = 0; w < 2; w++) begin
            checks++;
            if (act_addr[w] !== 32'(w * 4) || act_data[w] !== exp_word(w))
                $display("[TB] FAIL t6_word%0d: got %h:%h expected %h:%h", w, act_addr[w], act_data[w], 32'(w * 4), exp_word(w));
            else passes++;
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        test_reset();
        test_single_word();
        test_gaps();
        test_overflow();
        test_zero();
        test_reset_midload();
        test_ignore();
        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Global time bound so a stuck handshake can never hang the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
